muldiv_unit: RTL
================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the operand and result width and the iteration count.
REQ-002 The block SHALL have port CLK  input  1  single clock; all state changes on the rising edge.
REQ-003 The block SHALL have port RST_N  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port start  input  1  level request from the ALU, held high until finish is seen.
REQ-005 The block SHALL have port aluop  input  5  operation select: 01100 mult, 01101 multu, 01110 div, 01111 divu, 01001 mthi, 01011 mtlo.
REQ-006 The block SHALL have port aluA  input  DATA_W  rs operand (multiplicand, dividend, or mthi/mtlo data).
REQ-007 The block SHALL have port aluB  input  DATA_W  rt operand (multiplier or divisor).
REQ-008 The block SHALL have port hiOut  output  DATA_W  HI register: product upper half or remainder.
REQ-009 The block SHALL have port loOut  output  DATA_W  LO register: product lower half or quotient.
REQ-010 The block SHALL have port finish  output  1  result valid in HI/LO; completion handshake to the ALU.
REQ-011 The block SHALL have port busy  output  1  high in states BUSY and FIX.

Function
REQ-012 The block SHALL implement states IDLE, BUSY, FIX and DONE, encoded in a registered state variable.
REQ-013 In IDLE with start=1 and aluop in {01100..01111}, the block SHALL capture aluA, aluB and aluop, load iteration count DATA_W, and enter BUSY.
REQ-014 In IDLE, start=1 with any other aluop SHALL be ignored; the block stays in IDLE with finish=0.
REQ-015 In IDLE, aluop=01001 SHALL load hiOut<=aluA and aluop=01011 SHALL load loOut<=aluA on every edge, independent of start; these ops SHALL have no effect outside IDLE.
REQ-016 For signed ops, the block SHALL operate on magnitudes and record the result sign(s) at capture.
REQ-017 In BUSY, the block SHALL process one bit per cycle: shift-add for multiply, restoring shift-subtract for divide; the count decrements and the block enters FIX after DATA_W cycles.
REQ-018 FIX SHALL last one cycle and apply the sign: product negated (2*DATA_W bits) if the operand signs differ; quotient negated if the signs differ; remainder takes the sign of the dividend.
REQ-019 hiOut and loOut SHALL be updated only on the FIX->DONE edge, apart from mthi/mtlo.
REQ-020 Latency: finish SHALL rise DATA_W+2 edges after the capturing edge (34 for DATA_W=32).
REQ-021 In DONE, finish SHALL be 1; the block SHALL stay in DONE while start=1 and SHALL go to IDLE on the first edge with start=0.
REQ-022 hiOut and loOut SHALL hold their values until the next completion, mthi, mtlo or reset.
REQ-023 Changes on aluA, aluB or aluop during BUSY or FIX SHALL be ignored.
REQ-024 A start deassertion during BUSY SHALL NOT abort the operation; it completes, DONE lasts one cycle, and the block returns to IDLE.
REQ-025 Divide by zero SHALL produce loOut=all ones and hiOut=dividend (signed: hiOut=aluA), with the normal latency and no error flag.
REQ-026 Signed 0x80000000 / 0xFFFFFFFF SHALL give loOut=0x80000000 and hiOut=0.
REQ-027 finish SHALL be registered, not combinational from start, so the ALU's start=!finish path has no loop.

Reset
REQ-028 RST_N=0 SHALL immediately, without waiting for a clock edge, force state=IDLE, finish=0, busy=0, hiOut=0, loOut=0, and clear the count and operand registers.
REQ-029 A reset asserted in BUSY, FIX or DONE SHALL abandon the operation, and no partial result SHALL reach hiOut/loOut.
REQ-030 After RST_N rises, the first edge with start=1 and a valid op SHALL begin a new operation.

Verification
REQ-031 mult aluA=0xFFFFFFFF, aluB=0x00000002 -> finish after 34 edges; hiOut=0xFFFFFFFF, loOut=0xFFFFFFFE.
REQ-032 multu aluA=0xFFFFFFFF, aluB=0x00000002 -> hiOut=0x00000001, loOut=0xFFFFFFFE.
REQ-033 div aluA=0xFFFFFFF9 (-7), aluB=2 -> loOut=0xFFFFFFFD, hiOut=0xFFFFFFFF; divu 7/0 -> loOut=0xFFFFFFFF, hiOut=7.
REQ-034 Handshake: hold start=1 with mult, drop start the cycle after finish rises -> finish high for exactly 2 cycles, then IDLE; a second back-to-back mult starts correctly.
REQ-035 Assert RST_N=0 at BUSY cycle 10 of a divu -> finish=0, hiOut=loOut=0 immediately, state IDLE; a following operation gives the correct result.
REQ-036 In IDLE, mthi aluA=0x12345678 then mtlo aluA=0x9ABCDEF0 -> hiOut=0x12345678, loOut=0x9ABCDEF0; mthi during BUSY -> no change.

Source files
------------

// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - ALU-side request/result bundle for the multiply/divide unit
interface muldiv_unit_if #(
    parameter int DATA_W = 32
);
    logic              start;
    logic [4:0]        aluop;
    logic [DATA_W-1:0] aluA;
    logic [DATA_W-1:0] aluB;
    logic [DATA_W-1:0] hiOut;
    logic [DATA_W-1:0] loOut;
    logic              finish;
    logic              busy;

    modport master (
        output start, aluop, aluA, aluB,
        input  hiOut, loOut, finish, busy
    );

    modport slave (
        input  start, aluop, aluA, aluB,
        output hiOut, loOut, finish, busy
    );
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative signed/unsigned multiply and restoring divide with HI/LO registers
module muldiv_unit #(
    parameter int DATA_W = 32
) (
    input  logic          CLK,
    input  logic          RST_N,
    muldiv_unit_if.slave  bus
);
    localparam int         CNT_W   = $clog2(DATA_W + 1);
    localparam logic [4:0] OP_MTHI = 5'b01001;
    localparam logic [4:0] OP_MTLO = 5'b01011;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FIX, S_DONE} state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic [DATA_W-1:0]   r_hi;
    logic [DATA_W-1:0]   r_lo;
    logic                r_div;
    logic                r_neg_lo;
    logic                r_neg_hi;
    logic [DATA_W-1:0]   r_hi_out;
    logic [DATA_W-1:0]   r_lo_out;
    logic                r_finish;
    logic                r_busy;

    logic                w_go;
    logic                w_signed;
    logic                w_a_neg;
    logic                w_b_neg;
    logic [DATA_W-1:0]   w_a_mag;
    logic [DATA_W-1:0]   w_b_mag;
    logic [DATA_W:0]     w_sum;
    logic [DATA_W:0]     w_shift;
    logic                w_ge;
    logic [DATA_W-1:0]   w_diff;
    logic [2*DATA_W-1:0] w_prod_s;
    logic [DATA_W-1:0]   w_quo;
    logic [DATA_W-1:0]   w_rem;

    // Ops 01100..01111: bit1 selects divide, bit0 selects unsigned.
    assign w_go     = bus.start && (bus.aluop[4:2] == 3'b011);
    assign w_signed = ~bus.aluop[0];
    assign w_a_neg  = w_signed & bus.aluA[DATA_W-1];
    assign w_b_neg  = w_signed & bus.aluB[DATA_W-1];
    assign w_a_mag  = w_a_neg ? -bus.aluA : bus.aluA;
    assign w_b_mag  = w_b_neg ? -bus.aluB : bus.aluB;

    assign w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : '0);
    assign w_shift  = {r_hi, r_lo[DATA_W-1]};
    assign w_ge     = w_shift >= {1'b0, r_b};
    assign w_diff   = w_shift[DATA_W-1:0] - r_b;

    assign w_prod_s = r_neg_lo ? -{r_hi, r_lo} : {r_hi, r_lo};
    assign w_quo    = r_neg_lo ? -r_lo : r_lo;
    assign w_rem    = r_neg_hi ? -r_hi : r_hi;

    assign bus.hiOut  = r_hi_out;
    assign bus.loOut  = r_lo_out;
    assign bus.finish = r_finish;
    assign bus.busy   = r_busy;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_div    <= 1'b0;
            r_neg_lo <= 1'b0;
            r_neg_hi <= 1'b0;
            r_hi_out <= '0;
            r_lo_out <= '0;
            r_finish <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.aluop == OP_MTHI) r_hi_out <= bus.aluA;
                    if (bus.aluop == OP_MTLO) r_lo_out <= bus.aluA;
                    if (w_go) begin
                        r_div    <= bus.aluop[1];
                        r_cnt    <= CNT_W'(DATA_W);
                        r_a      <= w_a_mag;
                        r_b      <= w_b_mag;
                        r_hi     <= '0;
                        r_lo     <= bus.aluop[1] ? w_a_mag : w_b_mag;
                        // A zero divisor keeps the all-ones quotient unsigned-looking.
                        r_neg_lo <= (w_a_neg ^ w_b_neg) && !(bus.aluop[1] && (bus.aluB == '0));
                        r_neg_hi <= bus.aluop[1] & w_a_neg;
                        r_busy   <= 1'b1;
                        r_state  <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (r_cnt == '0) begin
                        r_state <= S_FIX;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                        if (r_div) begin
                            r_hi <= w_ge ? w_diff : w_shift[DATA_W-1:0];
                            r_lo <= {r_lo[DATA_W-2:0], w_ge};
                        end else begin
                            r_hi <= w_sum[DATA_W:1];
                            r_lo <= {w_sum[0], r_lo[DATA_W-1:1]};
                        end
                    end
                end
                S_FIX: begin
                    if (r_div) begin
                        r_hi_out <= w_rem;
                        r_lo_out <= w_quo;
                    end else begin
                        {r_hi_out, r_lo_out} <= w_prod_s;
                    end
                    r_busy   <= 1'b0;
                    r_finish <= 1'b1;
                    r_state  <= S_DONE;
                end
                S_DONE: begin
                    if (!bus.start) begin
                        r_finish <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
